demux1to4_deser: RTL
====================

# demux1to4_deser

Serial-to-parallel 1:4 demultiplexer for the DCT datapath. It reassembles words that an upstream 4:1 select-driven serializer emits one bit per cycle, and presents each word on a parallel port under a valid/ready handshake. Bit placement follows the team's fixed select mapping: sel 00↔lane 3, 01↔lane 2, 10↔lane 1, 11↔lane 0. It sits at the receive end of any serialized coefficient or control link inside the compression pipeline.

## Interface
- SLOTS, default 4: lanes per word. Power of two, ≥2.
- SEL_W, default $clog2(SLOTS): width of the slot/select counter. Derived; not overridden.

- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on clk.
- din  input  1  serial data bit.
- din_valid  input  1  din is meaningful this cycle.
- din_sof  input  1  start-of-word marker. Qualified by din_valid; forces the current bit into slot 0.
- sel  output  SEL_W  slot the next valid bit lands in. Uses the same encoding as the serializer's select.
- dout  output  SLOTS  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- overflow  output  1  sticky: a completed word was dropped because the output register was full.
- sync_err  output  1  one-cycle pulse: din_sof arrived while a partial word was in progress.

## Operation
- Reset (rst_n=0 at a clk edge) clears the following:
  - sel=0, shift register=0, dout=0, dout_valid=0, overflow=0, sync_err=0.
  - Any partial word is discarded.
- Accept: on din_valid=1 the bit is written into assembly register position SLOTS-1-sel, then sel increments modulo SLOTS.
  - For SLOTS=4, the first bit lands in bit 3 and the last in bit 0 (MSB-first).
- din_valid=0: sel and the assembly register hold their values. Gaps between bits are allowed.
- din_sof=1 with din_valid=1:
  - The bit is written to position SLOTS-1 and sel becomes 1.
  - Positions not yet written in the new word are cleared to 0.
  - If the old sel was ≠0, sync_err pulses the next cycle.
  - din_sof with din_valid=0 is ignored.
- Completion: a valid bit accepted with sel=SLOTS-1 completes the word.
  - The completed word (including that bit) transfers to dout if dout_valid=0, or if dout_valid=1 and dout_ready=1 in that same cycle. dout_valid is then 1 on the next cycle.
  - Otherwise the word is dropped, dout is unchanged, and overflow is set and held until reset.
- Handshake:
  - dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
  - A transfer occurs when dout_valid=1 and dout_ready=1. dout_valid falls the next cycle unless a new word loads in that same cycle.
- dout_ready while dout_valid=0 has no effect.
- Assembly register and output register are independent. Assembly of the next word continues while dout waits.

## Timing
- Latency: the last bit of a word is sampled at edge N; dout and dout_valid are updated at edge N, so they are visible in cycle N+1.
- Throughput: one word per SLOTS valid input cycles. Sustained operation without overflow requires dout_ready=1 at least once every SLOTS cycles.
- sel is registered and valid from the first cycle after reset. It is meant to drive the upstream serializer's select directly.
- Simultaneous completion and consumption: the new word loads and dout_valid stays 1, with no bubble.
- Simultaneous din_sof and completion cannot occur for SLOTS≥2, because sof forces slot 0.
- Reset during a partial word or a pending dout drops everything; outputs return to reset values the next cycle.

## Structure
- Shared package dct_pkg holds:
  - the DEMUX_SLOTS=4 default,
  - a sel-to-lane function, lane = SLOTS-1-sel, shared with the mux side so both ends use the same mapping.
- One sub-module is natural: slot_counter (SEL_W-bit modulo counter with increment enable and load-to-1). Everything else stays in one module.

## Test plan
- Reset then the serial bits 1,0,1,1 with din_valid=1 and dout_ready=1 → dout=4'b1011 with dout_valid=1 for one cycle. sel sequence is 0,1,2,3,0.
- Same bits with two din_valid=0 gap cycles inserted after the second bit → dout=4'b1011. sel holds its value during the gaps.
- dout_ready=0, send word 0xA, then 0x5 → dout holds 0xA, overflow=1 after the second word completes, and 0x5 is lost. Raise ready → a single transfer of 0xA.
- Words 0x3 and 0xC back-to-back with dout_ready asserted in the cycle the second word completes → dout goes 0x3 then 0xC, dout_valid stays continuously high across the load.
- Bits 1,1 then din_sof with bit 0, then bits 1,1,0 → sync_err pulses once and dout=4'b0110.
- rst_n=0 after two bits of a word, then bits 0,0,0,1 → dout=4'b0001. No stale bits remain and overflow=0.

Source files
------------

// File: rtl/dct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_pkg: shared constants and the sel-to-lane mapping of the DCT link |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dct_pkg;

    localparam int DEMUX_SLOTS = 4;

    // Mux and demux ends both use this so select N always means lane SLOTS-1-N.
    function automatic int unsigned sel_to_lane(input int unsigned slots,
                                                input int unsigned sel);
        return slots - 1 - sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_counter: SEL_W-bit modulo counter with increment and load-to-1   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slot_counter #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load_one,
    output logic [SEL_W-1:0] cnt
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Wraps naturally because the slot count is a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = SEL_W'(1);
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/demux1to4_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux1to4_deser: serial-to-parallel 1:SLOTS deserializer, valid/ready |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux1to4_deser
    import dct_pkg::*;
#(
    parameter int SLOTS = DEMUX_SLOTS,
    parameter int SEL_W = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [SEL_W-1:0] sel,
    output logic [SLOTS-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overflow,
    output logic             sync_err
);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] lane;
    logic [SLOTS-1:0] asm_q;
    logic [SLOTS-1:0] asm_d;
    logic [SLOTS-1:0] dout_q;
    logic [SLOTS-1:0] dout_d;
    logic             dout_valid_q;
    logic             dout_valid_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             sync_err_q;
    logic             sync_err_d;
    logic             word_done;
    logic             cnt_inc;
    logic             cnt_load;

    assign cnt_inc  = din_valid & ~din_sof;
    assign cnt_load = din_valid & din_sof;

    slot_counter #(
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .load_one (cnt_load),
        .cnt      (sel_q)
    );

    assign lane = SEL_W'(sel_to_lane(SLOTS, 32'(sel_q)));

    always_comb begin
        asm_d        = asm_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        sync_err_d   = 1'b0;
        word_done    = 1'b0;

        if (din_valid) begin
            if (din_sof) begin
                // Restart the word: stale bits of an aborted word must not leak through.
                asm_d            = '0;
                asm_d[SLOTS-1]   = din;
                sync_err_d       = (sel_q != '0);
            end else begin
                asm_d[lane] = din;
                word_done   = (sel_q == SEL_W'(SLOTS - 1));
            end
        end

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // A load in the same cycle as a consume keeps dout_valid high with no bubble.
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = asm_d;
                dout_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule
`default_nettype wire
